// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: turns two-byte UART command frames into the PWM duty level.
// Commands: 'O' sets the level immediately, 'L' ramps to a target, 'R' sets the ramp rate.
// Build option: define PWM_LEVEL_CTRL_TIMEOUT_EN to abandon a frame whose argument
// byte does not arrive within TIMEOUT_CLKS cycles.
//
// State      | Meaning
// -----------+------------------------------------------------
// S_IDLE     | waiting for a command byte
// S_WAIT_ARG | opcode latched, next strobed byte is the argument
module pwm_level_ctrl #(
    parameter int PRESCALE     = 1000,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic [7:0] level,
    output logic       busy,
    output logic       err
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_ARG = 1'b1
    } state_t;

    localparam logic [7:0] OP_L = 8'h4C;
    localparam logic [7:0] OP_O = 8'h4F;
    localparam logic [7:0] OP_R = 8'h52;

    // PRESCALE=1 still needs a one-bit counter; it simply ticks every cycle.
    localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [7:0]       r_opcode;
    logic [7:0]       r_level;
    logic [7:0]       r_target;
    logic [7:0]       r_rate;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [7:0]       r_rate_cnt;
    logic             r_busy;
    logic             r_err;

    logic             w_is_cmd;
    logic             w_exec;
    logic             w_err_n;
    logic             w_timeout;
    logic [7:0]       w_level_n;
    logic [7:0]       w_target_n;
    logic [7:0]       w_rate_n;
    logic [PRE_W-1:0] w_pre_n;
    logic [7:0]       w_rate_cnt_n;

    assign w_is_cmd = (rx_byte == OP_L) || (rx_byte == OP_O) || (rx_byte == OP_R);

`ifdef PWM_LEVEL_CTRL_TIMEOUT_EN
    localparam int             TO_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CLKS - 1);

    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == S_WAIT_ARG) && (r_to_cnt == TO_MAX);

    // Timeout counter: sits at 0 in IDLE, counts idle cycles while waiting for the argument
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_to_cnt <= '0;
        end else if (!rx_dv) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    // Without the timeout option the argument wait is unbounded; TIMEOUT_CLKS has no effect.
    assign w_timeout = (TIMEOUT_CLKS < 0);
`endif

    // Parser state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Parser next-state: a strobed byte always beats a timeout in the same cycle
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_dv && w_is_cmd) begin
                    w_state_n = S_WAIT_ARG;
                end
            end
            S_WAIT_ARG: begin
                if (rx_dv || w_timeout) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Parser outputs: execute strobe and error request
    always_comb begin
        w_exec  = 1'b0;
        w_err_n = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err_n = rx_dv && !w_is_cmd;
            end
            S_WAIT_ARG: begin
                w_exec  = rx_dv;
                w_err_n = !rx_dv && w_timeout;
            end
            default: begin
                w_exec  = 1'b0;
                w_err_n = 1'b0;
            end
        endcase
    end

    // Opcode latch: captured with the command byte, consumed with the argument
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opcode <= '0;
        end else if ((r_state == S_IDLE) && rx_dv && w_is_cmd) begin
            r_opcode <= rx_byte;
        end
    end

    // Ramp engine and command execution: next level, target, rate and tick counters
    always_comb begin
        w_level_n    = r_level;
        w_target_n   = r_target;
        w_rate_n     = r_rate;
        w_pre_n      = r_pre_cnt;
        w_rate_cnt_n = r_rate_cnt;
        if (w_exec && (r_opcode == OP_R)) begin
            w_rate_n = rx_byte;
        end
        if (w_exec && (r_opcode == OP_O)) begin
            w_level_n    = rx_byte;
            w_target_n   = rx_byte;
            w_pre_n      = '0;
            w_rate_cnt_n = '0;
        end else if (w_exec && (r_opcode == OP_L)) begin
            w_target_n   = rx_byte;
            w_pre_n      = '0;
            w_rate_cnt_n = '0;
        end else if (r_level == r_target) begin
            w_pre_n      = '0;
            w_rate_cnt_n = '0;
        end else if (r_pre_cnt == PRE_MAX) begin
            w_pre_n = '0;
            if (r_rate_cnt >= r_rate) begin
                w_rate_cnt_n = '0;
                // level != target here, so a single step can neither overshoot nor wrap
                if (r_level < r_target) begin
                    w_level_n = r_level + 8'd1;
                end else begin
                    w_level_n = r_level - 8'd1;
                end
            end else begin
                w_rate_cnt_n = r_rate_cnt + 8'd1;
            end
        end else begin
            w_pre_n = r_pre_cnt + PRE_W'(1);
        end
    end

    // Datapath registers; busy is derived from next values so it tracks level exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level    <= '0;
            r_target   <= '0;
            r_rate     <= '0;
            r_pre_cnt  <= '0;
            r_rate_cnt <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_level    <= w_level_n;
            r_target   <= w_target_n;
            r_rate     <= w_rate_n;
            r_pre_cnt  <= w_pre_n;
            r_rate_cnt <= w_rate_cnt_n;
            r_busy     <= (w_level_n != w_target_n);
            r_err      <= w_err_n;
        end
    end

    assign level = r_level;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Directed bench for pwm_level_ctrl with an expectation queue keyed by cycle number.
module tb_pwm_level_ctrl;

    localparam int PRESCALE     = 4;
    localparam int TIMEOUT_CLKS = 50;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] level;
    logic       busy;
    logic       err;

    int cyc    = 0;
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [7:0] lv;
        logic       b;
        logic       e;
        string      tag;
    } exp_t;

    exp_t q[$];

    pwm_level_ctrl #(
        .PRESCALE    (PRESCALE),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx_dv  (rx_dv),
        .rx_byte(rx_byte),
        .level  (level),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] lv, input logic b, input logic e);
        n_vec++;
        assert ({level, busy, err} === {lv, b, e}) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: got level=%0d busy=%b err=%b, expected level=%0d busy=%b err=%b",
                   tag, cyc, level, busy, err, lv, b, e);
        end
    endtask

    task automatic expect_at(input int c, input logic [7:0] lv, input logic b, input logic e,
                             input string tag);
        exp_t x;
        x.cyc = c;
        x.lv  = lv;
        x.b   = b;
        x.e   = e;
        x.tag = tag;
        q.push_back(x);
    endtask

    // Outputs are sampled mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                chk(q[i].tag, q[i].lv, q[i].b, q[i].e);
                q.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_at(input int c, input logic [7:0] b);
        wait_cyc(c);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output int a);
        a = cyc + 1;
        drive_at(a, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_vec++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: %0d expectations never reached, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int a;

        // Reset: outputs clear without any clock edge
        #1 reset = 1'b0;
        #1 chk("reset_async", 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_hold", 8'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // 1: immediate level
        send(8'h4F, c);
        expect_at(c + 1, 8'd0, 1'b0, 1'b0, "o_cmd_no_err");
        send(8'h64, a);
        expect_at(a + 1, 8'd100, 1'b0, 1'b0, "o_level");
        expect_at(a + 2, 8'd100, 1'b0, 1'b0, "o_hold");
        drain();

        // 2: rate 0 ramp 0 -> 3
        send(8'h4F, c);
        send(8'h00, a);
        expect_at(a + 1, 8'd0, 1'b0, 1'b0, "o_zero");
        drain();
        send(8'h4C, c);
        send(8'h03, a);
        expect_at(a + 1,  8'd0, 1'b1, 1'b0, "r0_busy");
        expect_at(a + 4,  8'd0, 1'b1, 1'b0, "r0_pre1");
        expect_at(a + 5,  8'd1, 1'b1, 1'b0, "r0_step1");
        expect_at(a + 8,  8'd1, 1'b1, 1'b0, "r0_pre2");
        expect_at(a + 9,  8'd2, 1'b1, 1'b0, "r0_step2");
        expect_at(a + 12, 8'd2, 1'b1, 1'b0, "r0_pre3");
        expect_at(a + 13, 8'd3, 1'b0, 1'b0, "r0_done");
        expect_at(a + 14, 8'd3, 1'b0, 1'b0, "r0_hold");
        drain();

        // 3: rate 2 ramp down 3 -> 0
        send(8'h52, c);
        send(8'h02, a);
        expect_at(a + 1, 8'd3, 1'b0, 1'b0, "r_set_idle");
        drain();
        send(8'h4C, c);
        send(8'h00, a);
        expect_at(a + 1,  8'd3, 1'b1, 1'b0, "r2_busy");
        expect_at(a + 12, 8'd3, 1'b1, 1'b0, "r2_pre1");
        expect_at(a + 13, 8'd2, 1'b1, 1'b0, "r2_step1");
        expect_at(a + 24, 8'd2, 1'b1, 1'b0, "r2_pre2");
        expect_at(a + 25, 8'd1, 1'b1, 1'b0, "r2_step2");
        expect_at(a + 36, 8'd1, 1'b1, 1'b0, "r2_pre3");
        expect_at(a + 37, 8'd0, 1'b0, 1'b0, "r2_done");
        drain();

        // 4: unknown opcode
        send(8'h58, c);
        expect_at(c + 1, 8'd0, 1'b0, 1'b1, "unk_err");
        expect_at(c + 2, 8'd0, 1'b0, 1'b0, "unk_err_end");
        drain();
        send(8'h4F, c);
        send(8'h10, a);
        expect_at(a + 1, 8'd16, 1'b0, 1'b0, "o_after_err");
        drain();

        // 5: argument timeout and the exact-boundary argument
        send(8'h4F, c);
        send(8'h20, a);
        expect_at(a + 1, 8'd32, 1'b0, 1'b0, "o_pre_to");
        drain();
`ifdef PWM_LEVEL_CTRL_TIMEOUT_EN
        send(8'h4C, c);
        expect_at(c + 50, 8'd32, 1'b0, 1'b0, "to_not_yet");
        expect_at(c + 51, 8'd32, 1'b0, 1'b1, "to_err");
        expect_at(c + 52, 8'd32, 1'b0, 1'b0, "to_err_end");
        drain();
        send(8'h10, a);
        expect_at(a + 1,  8'd32, 1'b0, 1'b1, "to_next_is_cmd");
        expect_at(a + 2,  8'd32, 1'b0, 1'b0, "to_next_err_end");
        expect_at(a + 12, 8'd32, 1'b0, 1'b0, "to_target_kept");
        drain();
`else
        send(8'h4F, c);
        expect_at(c + 51, 8'd32, 1'b0, 1'b0, "no_to_waiting");
        drain();
        send(8'h30, a);
        expect_at(a + 1, 8'd48, 1'b0, 1'b0, "no_to_late_arg");
        drain();
`endif
        send(8'h4F, c);
        drive_at(c + 50, 8'h40);
        a = c + 50;
        expect_at(a + 1, 8'd64, 1'b0, 1'b0, "to_boundary_exec");
        expect_at(a + 2, 8'd64, 1'b0, 1'b0, "to_boundary_no_err");
        drain();

        // 6: asynchronous reset in the middle of a ramp
        send(8'h4F, c);
        send(8'h02, a);
        drain();
        send(8'h4C, c);
        send(8'hC8, a);
        expect_at(a + 1, 8'd2, 1'b1, 1'b0, "pre_rst_busy");
        expect_at(a + 5, 8'd2, 1'b1, 1'b0, "pre_rst_level");
        drain();
        wait_cyc(a + 6);
        #2 reset = 1'b0;
        #1 chk("rst_mid_ramp", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_held", 8'd0, 1'b0, 1'b0);
        reset = 1'b1;
        send(8'h4F, c);
        send(8'h05, a);
        expect_at(a + 1, 8'd5, 1'b0, 1'b0, "post_rst_o");
        drain();
        // rate must have returned to 0
        send(8'h4C, c);
        send(8'h07, a);
        expect_at(a + 1, 8'd5, 1'b1, 1'b0, "post_rst_ramp_busy");
        expect_at(a + 5, 8'd6, 1'b1, 1'b0, "post_rst_step1");
        expect_at(a + 9, 8'd7, 1'b0, 1'b0, "post_rst_done");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
